wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback arbiter for the single register-file write port.
- Merges the in-order single-cycle ALU result stream with a long-latency result stream (load unit, mul/div) buffered in a small FIFO.
- Drives the registered write triple (regWEn, rsW, data_W) into the register file.
- Exports a pending-destination mask so hazard logic can stall readers of registers whose long-latency write has not yet retired.

Parameters:
- DEPTH, 4: long-latency FIFO entries; power of two, at least 2.
- STARVE_MAX, 8: consecutive cycles the FIFO head may lose to the ALU before the ALU is stalled for one cycle; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result valid this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- o_alu_stall  out  1  ALU input not consumed this cycle; upstream holds alu_valid, alu_rd and alu_data stable.
- ll_valid  in  1  long-latency result offered.
- ll_ready  out  1  FIFO can accept; ll_ready = !full.
- ll_rd  in  5  long-latency destination register.
- ll_data  in  32  long-latency result.
- o_regWEn  out  1  register-file write enable.
- o_rsW  out  5  register-file write address.
- o_data_W  out  32  register-file write data.
- o_pending_mask  out  32  bit r set when a valid FIFO entry targets r; bit 0 always 0.

Behaviour:
- Reset (async, i_reset=1):
  - FIFO empty, with read/write pointers and count at 0.
  - Starvation counter at 0.
  - o_regWEn=0, o_rsW=0, o_data_W=0, o_alu_stall=0, o_pending_mask=0.
  - ll_ready=1 once reset deasserts.
  - Any in-flight FIFO content is lost.
- Enqueue:
  - Occurs on a cycle with ll_valid && ll_ready.
  - An entry with ll_rd==0 is accepted and discarded; it is not stored.
  - There is no same-cycle push-while-full, because ll_ready depends only on the current count.
- Selection, per cycle, in priority order:
  - (a) o_alu_stall==1 and FIFO non-empty: pop the head and write it. ALU input is ignored this cycle.
  - (b) alu_valid && alu_rd!=0: write the ALU result.
  - (c) FIFO non-empty: pop the head and write it. This includes the case alu_valid && alu_rd==0, where the ALU write is a no-op and is consumed.
  - (d) Otherwise: no write.
- Latency:
  - The selected write appears on o_regWEn/o_rsW/o_data_W at the next rising edge.
  - Outputs are registered, so input at edge N gives the write at N+1.
  - When no write is selected, o_regWEn=0 and o_rsW/o_data_W hold their previous values.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and case (b) wins.
  - It clears on every pop, and whenever the FIFO is empty.
  - When the counter reaches STARVE_MAX, o_alu_stall is registered high for exactly one cycle, and the counter clears.
  - o_alu_stall never asserts on consecutive cycles.
  - If the FIFO empties before the stall cycle, case (a) degenerates to no write, and the ALU input is still held.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, pointers both advance and wrap modulo DEPTH.
- Push into an empty FIFO: the entry is not eligible for a pop until the next cycle. There is no FIFO bypass.
- o_pending_mask:
  - Combinational OR of one-hot(rd) over valid FIFO entries, plus the entry held in the output register while o_regWEn=1.
  - Duplicate rd values are permitted; the bit clears only when the last matching entry retires.
- Ordering:
  - FIFO entries retire in arrival order.
  - There is no ordering guarantee between the ALU and long-latency streams. Hazard logic uses o_pending_mask to prevent WAW/RAW conflicts.
- Reset mid-operation: the FIFO is flushed and outputs are forced to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset with no traffic, then alu_valid=1, alu_rd=5, alu_data=0x1234 at edge 1 -> o_regWEn=1, o_rsW=5, o_data_W=0x1234 after edge 2; o_pending_mask=0x20 during that cycle.
- ll push rd=7, data=0xDEAD with the ALU idle -> ll_ready=1, mask bit 7 set; write of rd=7, data=0xDEAD two edges after the push; mask returns to 0 after retire.
- Fill FIFO with DEPTH=4 pushes (rd=1..4) while the ALU writes every cycle -> ll_ready=0 after 4 pushes; o_alu_stall pulses after 8 ALU wins; rd=1 is written in the stall cycle; the ALU value held during the stall is written the following cycle; no writes are lost.
- ll push rd=0 and ALU rd=0 -> no o_regWEn; FIFO count stays 0; mask stays 0.
- Wrap-around: 10 push/pop pairs with rd=1..10 and data=i*0x11 -> writes appear in order with the correct data.
- Assert i_reset mid-drain with 3 entries queued -> o_regWEn, o_pending_mask and o_alu_stall drop to 0 asynchronously; after release, ll_ready=1 and no stale writes appear.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the single register-file write port.
//   Merges the single-cycle ALU result stream with a long-latency result
//   stream (load unit, mul/div) that is buffered in a small FIFO. It drives
//   a registered write triple into the register file. It also exports a
//   pending-destination mask, which hazard logic uses to stall readers.
//
// Ports:
//   clk, i_reset           clock (rising edge); async active-high reset
//   alu_valid/rd/data      ALU result offered this cycle
//   o_alu_stall            ALU input not consumed this cycle (upstream holds)
//   ll_valid/rd/data       long-latency result offered
//   ll_ready               FIFO can accept (not full)
//   o_regWEn/o_rsW/o_data_W  registered register-file write
//   o_pending_mask         one-hot OR of destinations still in flight
module wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        o_alu_stall,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_data,
    output logic        o_regWEn,
    output logic [4:0]  o_rsW,
    output logic [31:0] o_data_W,
    output logic [31:0] o_pending_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [DEPTH-1:0][4:0]  fifo_rd;
    logic [DEPTH-1:0][31:0] fifo_data;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [SW-1:0]          starve_cnt, starve_nxt;
    logic                   stall_nxt;

    logic empty, push, pop, alu_win;

    assign empty    = (count == '0);
    assign ll_ready = (count != CW'(DEPTH));
    // rd==0 results are accepted but never stored: x0 is not writable.
    assign push     = ll_valid && ll_ready && (ll_rd != 5'd0);
    // The stall cycle belongs to the FIFO head; the ALU input is ignored then.
    assign alu_win  = !o_alu_stall && alu_valid && (alu_rd != 5'd0);
    // The head pops in the stall cycle, or whenever the ALU has nothing real
    // to write. A push into an empty FIFO is not visible here until next
    // cycle because count is registered.
    assign pop      = !empty && (o_alu_stall || !alu_win);

    // Starvation: count ALU wins while the head waits. On reaching the
    // limit, force one stall cycle. The stall can only be set from an ALU win,
    // and the stall cycle itself never has one, so stalls are never
    // back-to-back.
    always_comb begin
        starve_nxt = starve_cnt;
        stall_nxt  = 1'b0;
        if (empty || pop) begin
            starve_nxt = '0;
        end else if (alu_win) begin
            if (starve_cnt == SW'(STARVE_MAX - 1)) begin
                starve_nxt = '0;
                stall_nxt  = 1'b1;
            end else begin
                starve_nxt = starve_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            starve_cnt  <= '0;
            o_alu_stall <= 1'b0;
            o_regWEn    <= 1'b0;
            o_rsW       <= '0;
            o_data_W    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count       <= count + CW'(push) - CW'(pop);
            starve_cnt  <= starve_nxt;
            o_alu_stall <= stall_nxt;
            if (alu_win) begin
                o_regWEn <= 1'b1;
                o_rsW    <= alu_rd;
                o_data_W <= alu_data;
            end else if (pop) begin
                o_regWEn <= 1'b1;
                o_rsW    <= fifo_rd[rd_ptr];
                o_data_W <= fifo_data[rd_ptr];
            end else begin
                o_regWEn <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entry validity comes from count/rd_ptr alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= ll_rd;
            fifo_data[wr_ptr] <= ll_data;
        end
    end

    // Entry i is live when its distance from the head is below count.
    always_comb begin
        logic [PW-1:0] off;
        off            = '0;
        o_pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (CW'(off) < count) o_pending_mask[fifo_rd[i]] = 1'b1;
        end
        if (o_regWEn) o_pending_mask[o_rsW] = 1'b1;
        o_pending_mask[0] = 1'b0;
    end

endmodule
